// File: rtl/ttt_token_accumulator.sv
// ---------------------------------------------------------------------------
// ttt_token_accumulator: per-processor saturating good/bad token counters that
// push a processor id into a fire queue when its thresholds are met. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ttt_token_accumulator #(
  parameter int NUM_PROCESSORS = 10,
  parameter int NEW_TOKEN_BITS = 4,
  parameter int TOKEN_BITS     = 8,
  parameter int FIFO_DEPTH     = 4,
  localparam int IDW = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  output logic                      ready,
  input  logic [IDW-1:0]            target_id,
  input  logic [NEW_TOKEN_BITS-1:0] new_good_tokens,
  input  logic [NEW_TOKEN_BITS-1:0] new_bad_tokens,
  input  logic [2:0]                instruction,
  input  logic [IDW-1:0]            prog_id,
  input  logic [TOKEN_BITS-1:0]     prog_value,
  output logic                      fire_valid,
  input  logic                      fire_ready,
  output logic [IDW-1:0]            fire_id
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PTRW + 1;

  localparam logic signed [TOKEN_BITS-1:0] c_TOK_MAX = {1'b0, {(TOKEN_BITS-1){1'b1}}};
  localparam logic signed [TOKEN_BITS-1:0] c_TOK_MIN = {1'b1, {(TOKEN_BITS-1){1'b0}}};
  localparam logic [IDW:0]                 c_NPROC    = (IDW+1)'(NUM_PROCESSORS);
  localparam logic [CNTW-1:0]              c_DEPTH    = CNTW'(FIFO_DEPTH);
  localparam logic [PTRW-1:0]              c_PTR_LAST = PTRW'(FIFO_DEPTH - 1);

  localparam logic [2:0] c_OP_NOP      = 3'b000;
  localparam logic [2:0] c_OP_THR_GOOD = 3'b001;
  localparam logic [2:0] c_OP_THR_BAD  = 3'b010;
  localparam logic [2:0] c_OP_CLR_ONE  = 3'b011;
  localparam logic [2:0] c_OP_FLUSH    = 3'b100;

  logic signed [TOKEN_BITS-1:0] good_q     [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] good_d     [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] bad_q      [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] bad_d      [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] thr_good_q [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] thr_good_d [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] thr_bad_q  [NUM_PROCESSORS];
  logic signed [TOKEN_BITS-1:0] thr_bad_d  [NUM_PROCESSORS];

  logic [IDW-1:0]  fifo_q [FIFO_DEPTH];
  logic [IDW-1:0]  fifo_d [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic                         tgt_ok, prog_ok, accept, fire, push, pop;
  logic [IDW-1:0]               tgt_idx, prog_idx;
  logic signed [TOKEN_BITS-1:0] good_next, bad_next;

  // One guard bit catches overflow; clamp to the extreme of the sum's true sign.
  function automatic logic signed [TOKEN_BITS-1:0] sat_add(
    input logic [TOKEN_BITS-1:0]     a,
    input logic [NEW_TOKEN_BITS-1:0] b
  );
    logic [TOKEN_BITS:0] s;
    s = {a[TOKEN_BITS-1], a} + {{(TOKEN_BITS+1-NEW_TOKEN_BITS){b[NEW_TOKEN_BITS-1]}}, b};
    if (s[TOKEN_BITS] != s[TOKEN_BITS-1]) begin
      return s[TOKEN_BITS] ? c_TOK_MIN : c_TOK_MAX;
    end
    return s[TOKEN_BITS-1:0];
  endfunction

  assign ready      = reset && (instruction == c_OP_NOP) && (count_q < c_DEPTH);
  assign fire_valid = reset && (count_q != '0);
  assign fire_id    = fire_valid ? fifo_q[rd_ptr_q] : '0;

  assign tgt_ok   = {1'b0, target_id} < c_NPROC;
  assign prog_ok  = {1'b0, prog_id} < c_NPROC;
  assign tgt_idx  = tgt_ok ? target_id : '0;
  assign prog_idx = prog_ok ? prog_id : '0;
  assign accept   = valid && ready;

  assign good_next = sat_add(good_q[tgt_idx], new_good_tokens);
  assign bad_next  = sat_add(bad_q[tgt_idx], new_bad_tokens);
  assign fire      = (good_next >= thr_good_q[tgt_idx]) && (bad_next < thr_bad_q[tgt_idx]);
  assign push      = accept && tgt_ok && fire;
  assign pop       = fire_valid && fire_ready;

  always_comb begin
    good_d     = good_q;
    bad_d      = bad_q;
    thr_good_d = thr_good_q;
    thr_bad_d  = thr_bad_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept && tgt_ok) begin
      if (fire) begin
        good_d[tgt_idx] = '0;
        bad_d[tgt_idx]  = '0;
      end else begin
        good_d[tgt_idx] = good_next;
        bad_d[tgt_idx]  = bad_next;
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = target_id;
      wr_ptr_d         = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + PTRW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNTW'(1);
    end

    // Updates only land on NOP cycles, so programming never collides with them.
    case (instruction)
      c_OP_THR_GOOD: if (prog_ok) thr_good_d[prog_idx] = prog_value;
      c_OP_THR_BAD:  if (prog_ok) thr_bad_d[prog_idx] = prog_value;
      c_OP_CLR_ONE: begin
        if (prog_ok) begin
          good_d[prog_idx] = '0;
          bad_d[prog_idx]  = '0;
        end
      end
      c_OP_FLUSH: begin
        for (int i = 0; i < NUM_PROCESSORS; i++) begin
          good_d[i] = '0;
          bad_d[i]  = '0;
        end
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        good_q[i]     <= '0;
        bad_q[i]      <= '0;
        thr_good_q[i] <= c_TOK_MAX;
        thr_bad_q[i]  <= c_TOK_MIN;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      good_q     <= good_d;
      bad_q      <= bad_d;
      thr_good_q <= thr_good_d;
      thr_bad_q  <= thr_bad_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
    fifo_q <= fifo_d;
  end

endmodule

`default_nettype wire
